cp0_intr_ctrl: RTL

- Prioritised external-interrupt controller in front of CP0 in cpu_with_cp0.
- Synchronises NUM_IRQ asynchronous device lines and holds per-line mask, edge/level mode and pending state.
- Presents one interrupt request with its cause number to CP0 over a req/ack handshake, then blocks further requests until CP0 signals eret.
- The CPU configures it through a small register port driven by mtc0/mfc0-style accesses.

---
 rtl/cp0_intr_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cp0_intr_ctrl.sv
// Purpose: prioritised external-interrupt controller in front of CP0 (sync, mask, edge/level, pending, req/ack/eret).
// Latency: irq_in rising before edge k gives int_req after edge k+3; cfg writes take effect after the edge.
// Backpressure: one request outstanding; further requests are held until CP0 acks and then issues eret.
// Ports: clk/rst (async active-low), irq_in[NUM_IRQ], cfg_we/cfg_addr/cfg_wdata/cfg_rdata register port,
//        int_req/int_cause/int_ack request handshake to CP0, eret return pulse, in_service handler-active flag.
module cp0_intr_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               int_req,
  output logic [ID_W-1:0]    int_cause,
  input  logic               int_ack,
  input  logic               eret,
  output logic               in_service
);

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_EDGE   = 2'd1;
  localparam logic [1:0] ADDR_PEND   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] s1, s2, s2_d;
  logic [NUM_IRQ-1:0] mask_r, edge_r, pend_r;

  logic [NUM_IRQ-1:0] rise, w1c, ack_clr, clr, pend_nxt, elig;
  logic [ID_W-1:0]    win_id;
  logic               ack_fire;

  // Only the low NUM_IRQ bits of the write data carry register content.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata[31:NUM_IRQ];

  // Two-flop synchroniser plus one delayed copy for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      s2_d <= '0;
    end else begin
      s1   <= irq_in;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign rise     = s2 & ~s2_d;
  assign ack_fire = (state == ST_REQ) && int_ack;
  assign w1c      = (cfg_we && cfg_addr == ADDR_PEND) ? cfg_wdata[NUM_IRQ-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    if (ack_fire) ack_clr[int_cause] = 1'b1;
  end

  // Clears only touch edge-mode bits; a fresh edge in the same cycle wins
  // over the clear. Level-mode bits simply mirror the synchronised line.
  assign clr      = (w1c | ack_clr) & edge_r;
  assign pend_nxt = (edge_r & (rise | (pend_r & ~clr))) | (~edge_r & s2);
  assign elig     = pend_r & mask_r;

  // Lowest-numbered eligible line wins: scan from the top so the last hit is the lowest.
  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) win_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_r <= '0;
      edge_r <= '0;
      pend_r <= '0;
    end else begin
      pend_r <= pend_nxt;
      if (cfg_we && cfg_addr == ADDR_MASK) mask_r <= cfg_wdata[NUM_IRQ-1:0];
      if (cfg_we && cfg_addr == ADDR_EDGE) edge_r <= cfg_wdata[NUM_IRQ-1:0];
    end
  end

  // Request FSM. The cause is latched on entry to REQ and held through SVC,
  // so masking or a dropped line cannot retract an offered request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      int_req    <= 1'b0;
      int_cause  <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|elig) begin
            int_cause <= win_id;
            int_req   <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            int_req    <= 1'b0;
            in_service <= 1'b1;
            state      <= ST_SVC;
          end
        end
        ST_SVC: begin
          if (eret) begin
            in_service <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          int_req    <= 1'b0;
          in_service <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MASK: cfg_rdata[NUM_IRQ-1:0] = mask_r;
      ADDR_EDGE: cfg_rdata[NUM_IRQ-1:0] = edge_r;
      ADDR_PEND: cfg_rdata[NUM_IRQ-1:0] = pend_r;
      ADDR_STATUS: begin
        cfg_rdata[1:0]      = state;
        cfg_rdata[2]        = in_service;
        cfg_rdata[8 +: ID_W] = int_cause;
      end
      default: cfg_rdata = '0;
    endcase
  end

endmodule
